// File: rtl/pio_rx_engine.sv
// rtl/pio_rx_engine.sv - PCIe PIO receive TLP decoder for single-DW memory reads and writes
module pio_rx_engine #(
  parameter int TCQ = 1
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic [21:0] m_axis_rx_tuser,
  output logic        req_compl,
  output logic        req_compl_wd,
  input  logic        compl_done,
  output logic [2:0]  req_tc,
  output logic        req_td,
  output logic        req_ep,
  output logic [1:0]  req_attr,
  output logic [9:0]  req_len,
  output logic [15:0] req_rid,
  output logic [7:0]  req_tag,
  output logic [7:0]  req_be,
  output logic [12:0] req_addr,
  output logic [13:0] rd_addr,
  output logic [3:0]  rd_be,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_be,
  output logic [31:0] wr_data,
  output logic        wr_en,
  input  logic        wr_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_DATA64,
    S_WR,
    S_RD_CPL,
    S_DRAIN
  } state_t;

  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] MRD64 = 7'h20;
  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  fmt_type;
  logic [1:0]  region;
  logic        hs;
  logic        hdr_ok;
  logic        is_wr;
  logic        is_4dw;
  logic [13:0] addr_lo;
  logic        unused_inputs;

  assign hs      = m_axis_rx_tvalid && m_axis_rx_tready;
  assign is_wr   = (fmt_type == MWR32) || (fmt_type == MWR64);
  assign is_4dw  = (fmt_type == MRD64) || (fmt_type == MWR64);
  // 4DW headers carry the low address DW in the upper half of beat 1
  assign addr_lo = is_4dw ? m_axis_rx_tdata[45:32] : m_axis_rx_tdata[13:0];

  assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:5], m_axis_rx_tuser[3],
                           m_axis_rx_tuser[1:0], (TCQ != 0)};

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Decide on beat 0 whether this TLP is one we execute or one we drain
  always_comb begin
    hdr_ok = 1'b0;
    case (m_axis_rx_tdata[30:24])
      MRD32, MRD64: hdr_ok = 1'b1;
      MWR32, MWR64: hdr_ok = !m_axis_rx_tdata[14];
      default:      hdr_ok = 1'b0;
    endcase
    if (m_axis_rx_tdata[9:0] != 10'd1) hdr_ok = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-state handshake/strobe outputs
  always_comb begin
    state_nxt        = state;
    m_axis_rx_tready = 1'b0;
    wr_en            = 1'b0;
    req_compl        = 1'b0;
    req_compl_wd     = 1'b0;
    case (state)
      S_IDLE: begin
        m_axis_rx_tready = 1'b1;
        if (m_axis_rx_tvalid && !m_axis_rx_tlast) state_nxt = hdr_ok ? S_HDR2 : S_DRAIN;
      end
      S_HDR2: begin
        m_axis_rx_tready = 1'b1;
        if (m_axis_rx_tvalid) begin
          if (!is_wr)      state_nxt = S_RD_CPL;
          else if (is_4dw) state_nxt = S_DATA64;
          else             state_nxt = S_WR;
        end
      end
      S_DATA64: begin
        m_axis_rx_tready = 1'b1;
        if (m_axis_rx_tvalid) state_nxt = S_WR;
      end
      S_WR: begin
        wr_en = 1'b1;
        if (!wr_busy) state_nxt = S_IDLE;
      end
      S_RD_CPL: begin
        req_compl    = 1'b1;
        req_compl_wd = 1'b1;
        if (compl_done) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        m_axis_rx_tready = 1'b1;
        if (m_axis_rx_tvalid && m_axis_rx_tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (sys_rst) m_axis_rx_tready = 1'b0;
  end

  // Capture header, address and payload fields as their beats are accepted
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      fmt_type <= '0;
      region   <= '0;
      req_tc   <= '0;
      req_td   <= 1'b0;
      req_ep   <= 1'b0;
      req_attr <= '0;
      req_len  <= '0;
      req_rid  <= '0;
      req_tag  <= '0;
      req_be   <= '0;
      req_addr <= '0;
      rd_addr  <= '0;
      rd_be    <= '0;
      wr_addr  <= '0;
      wr_be    <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (hs) begin
          fmt_type <= m_axis_rx_tdata[30:24];
          req_tc   <= m_axis_rx_tdata[22:20];
          req_td   <= m_axis_rx_tdata[15];
          req_ep   <= m_axis_rx_tdata[14];
          req_attr <= m_axis_rx_tdata[13:12];
          req_len  <= m_axis_rx_tdata[9:0];
          req_rid  <= m_axis_rx_tdata[63:48];
          req_tag  <= m_axis_rx_tdata[47:40];
          req_be   <= m_axis_rx_tdata[39:32];
          region   <= m_axis_rx_tuser[2] ? 2'b01 : (m_axis_rx_tuser[4] ? 2'b10 : 2'b00);
        end
        S_HDR2: if (hs) begin
          req_addr <= addr_lo[12:0];
          if (is_wr) begin
            wr_addr <= {region, addr_lo[13:2]};
            wr_be   <= {4'h0, req_be[3:0]};
            if (!is_4dw) wr_data <= bswap(m_axis_rx_tdata[63:32]);
          end else begin
            rd_addr <= {region, addr_lo[13:2]};
            rd_be   <= req_be[3:0];
          end
        end
        S_DATA64: if (hs) wr_data <= bswap(m_axis_rx_tdata[31:0]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_rx_engine.sv
// tb/tb_pio_rx_engine.sv - directed and randomized self-checking bench for pio_rx_engine
`timescale 1ns/1ps
module tb_pio_rx_engine;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [21:0] tuser;
  logic        req_compl, req_compl_wd, compl_done;
  logic [2:0]  req_tc;
  logic        req_td, req_ep;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [15:0] req_rid;
  logic [7:0]  req_tag, req_be;
  logic [12:0] req_addr;
  logic [13:0] rd_addr, wr_addr;
  logic [3:0]  rd_be;
  logic [7:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en, wr_busy;

  always #5 clk = ~clk;

  pio_rx_engine #(.TCQ(1)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep), .m_axis_rx_tlast(tlast),
    .m_axis_rx_tvalid(tvalid), .m_axis_rx_tready(tready), .m_axis_rx_tuser(tuser),
    .req_compl(req_compl), .req_compl_wd(req_compl_wd), .compl_done(compl_done),
    .req_tc(req_tc), .req_td(req_td), .req_ep(req_ep), .req_attr(req_attr),
    .req_len(req_len), .req_rid(req_rid), .req_tag(req_tag), .req_be(req_be),
    .req_addr(req_addr), .rd_addr(rd_addr), .rd_be(rd_be), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [6:0]  ft;
    logic [9:0]  len;
    logic        ep;
    logic        bar0;
    logic        bar2;
    logic [31:0] addr_lo;
    logic [31:0] addr_hi;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [2:0]  tc;
    logic        td;
    logic [1:0]  attr;
    int          busy;
    int          wait_cpl;
    logic        rst_in_cpl;
  } tlp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {req_compl, req_compl_wd, req_tc, req_td, req_ep, req_attr,
                        req_len, req_rid, req_tag}, 64'h0);
    chk({tag, "_ports"}, {req_be, req_addr, rd_addr, rd_be, wr_addr, wr_be, wr_en, tready}, 64'h0);
    chk({tag, "_wr_data"}, wr_data, 64'h0);
  endtask

  function automatic tlp_t mk_tlp(input logic [6:0] ft);
    tlp_t t;
    t.ft = ft; t.len = 10'd1; t.ep = 1'b0; t.bar0 = 1'b1; t.bar2 = 1'b0;
    t.addr_lo = 32'h0; t.addr_hi = 32'h0; t.fbe = 4'hF; t.lbe = 4'h0;
    t.data = 32'h0; t.tag = 8'h0; t.rid = 16'h0; t.tc = 3'd0; t.td = 1'b0;
    t.attr = 2'd0; t.busy = 0; t.wait_cpl = 1; t.rst_in_cpl = 1'b0;
    return t;
  endfunction

  // Build the beats of one TLP from its DW list, send them, then check the
  // expected effect: a write, a completion request, or nothing at all.
  task automatic run_tlp(input tlp_t t);
    logic [31:0] dws[$];
    logic [31:0] swapped;
    logic [1:0]  reg_exp;
    logic        is_rd, is_wr, accept;
    int          data_dw, nbeats, to;
    is_rd   = (t.ft == 7'h00) || (t.ft == 7'h20);
    is_wr   = (t.ft == 7'h40) || (t.ft == 7'h60);
    accept  = (is_rd || (is_wr && !t.ep)) && (t.len == 10'd1);
    reg_exp = t.bar0 ? 2'b01 : (t.bar2 ? 2'b10 : 2'b00);
    swapped = {<<8{t.data}};
    data_dw = t.ft[6] ? int'(t.len) : 0;
    dws = {};
    dws.push_back({1'b0, t.ft, 1'b0, t.tc, 4'h0, t.td, t.ep, t.attr, 2'b00, t.len});
    dws.push_back({t.rid, t.tag, t.lbe, t.fbe});
    if (t.ft[5]) begin
      dws.push_back(t.addr_hi);
      dws.push_back(t.addr_lo);
    end else begin
      dws.push_back(t.addr_lo);
    end
    for (int i = 0; i < data_dw; i++) dws.push_back(i == 0 ? t.data : $urandom());
    if (dws.size() % 2 != 0) dws.push_back($urandom());
    nbeats = dws.size() / 2;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, 1)) tick();
      tdata  = {dws[2*b+1], dws[2*b]};
      tlast  = (b == nbeats - 1);
      tuser  = (b == 0) ? {17'h0, t.bar2, 1'b0, t.bar0, 2'b00} : 22'($urandom());
      tkeep  = 8'hFF;
      tvalid = 1'b1;
      to = 0;
      while (!tready && to < 50) begin
        tick();
        to++;
      end
      chk("beat_ready", tready, 1);
      tick();
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (b != nbeats - 1) begin
        chk("mid_no_wr", wr_en, 0);
        chk("mid_no_cpl", req_compl, 0);
      end
    end
    if (accept && is_wr) begin
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, {reg_exp, t.addr_lo[13:2]});
      chk("wr_be", wr_be, {4'h0, t.fbe});
      chk("wr_data", wr_data, swapped);
      chk("wr_tready", tready, 0);
      chk("wr_no_cpl", req_compl, 0);
      wr_busy = (t.busy > 0);
      for (int i = 0; i < t.busy; i++) begin
        tick();
        chk("wr_hold_en", wr_en, 1);
        chk("wr_hold_data", wr_data, swapped);
        chk("wr_hold_addr", wr_addr, {reg_exp, t.addr_lo[13:2]});
      end
      wr_busy = 1'b0;
      tick();
      chk("wr_done_en", wr_en, 0);
      chk("wr_done_tready", tready, 1);
    end else if (accept) begin
      chk("rd_cpl", req_compl, 1);
      chk("rd_cpl_wd", req_compl_wd, 1);
      chk("rd_addr", rd_addr, {reg_exp, t.addr_lo[13:2]});
      chk("rd_be", rd_be, t.fbe);
      chk("rd_tag", req_tag, t.tag);
      chk("rd_rid", req_rid, t.rid);
      chk("rd_len", req_len, 1);
      chk("rd_req_addr", req_addr, t.addr_lo[12:0]);
      chk("rd_req_be", req_be, {t.lbe, t.fbe});
      chk("rd_attr_bits", {req_tc, req_td, req_ep, req_attr}, {t.tc, t.td, t.ep, t.attr});
      chk("rd_tready", tready, 0);
      chk("rd_no_wr", wr_en, 0);
      if (t.rst_in_cpl) begin
        sys_rst = 1'b1;
        tick();
        chk_zero("rst_in_cpl");
        sys_rst = 1'b0;
        tick();
        chk("rst_rel_tready", tready, 1);
        chk("rst_rel_cpl", req_compl, 0);
      end else begin
        for (int i = 1; i < t.wait_cpl; i++) begin
          tick();
          chk("cpl_hold", req_compl, 1);
          chk("cpl_hold_tready", tready, 0);
          chk("cpl_hold_tag", req_tag, t.tag);
        end
        compl_done = 1'b1;
        tick();
        compl_done = 1'b0;
        chk("cpl_clear", req_compl, 0);
        chk("cpl_wd_clear", req_compl_wd, 0);
        chk("cpl_tready", tready, 1);
      end
    end else begin
      chk("drop_no_wr", wr_en, 0);
      chk("drop_no_cpl", req_compl, 0);
      chk("drop_tready", tready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    tlp_t t;
    logic [6:0] fts [8];
    fts = '{7'h00, 7'h20, 7'h40, 7'h60, 7'h00, 7'h40, 7'h02, 7'h4A};
    sys_rst = 1'b1; tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    tuser = '0; compl_done = 1'b0; wr_busy = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    sys_rst = 1'b0;
    tick();
    chk("idle_tready", tready, 1);

    t = mk_tlp(7'h40); t.addr_lo = 32'h8; t.data = 32'h67452301;
    run_tlp(t);
    chk("mwr32_addr_const", wr_addr, 14'h1002);
    chk("mwr32_data_const", wr_data, 32'h01234567);

    t = mk_tlp(7'h20); t.tag = 8'h5A; t.rid = 16'h0100; t.wait_cpl = 10;
    t.addr_hi = 32'h0; t.addr_lo = 32'h0;
    run_tlp(t);
    chk("mrd64_addr_const", rd_addr, 14'h1000);

    t = mk_tlp(7'h40); t.addr_lo = 32'h0000_1234; t.data = 32'hDEADBEEF; t.busy = 3;
    run_tlp(t);

    t = mk_tlp(7'h40); t.len = 10'd2; t.data = 32'h11112222;
    run_tlp(t);
    t = mk_tlp(7'h02);
    run_tlp(t);
    t = mk_tlp(7'h00); t.addr_lo = 32'h0000_0ABC; t.tag = 8'h21; t.wait_cpl = 2;
    run_tlp(t);

    t = mk_tlp(7'h40); t.ep = 1'b1; t.data = 32'hCAFEF00D;
    run_tlp(t);
    t = mk_tlp(7'h00); t.bar0 = 1'b0; t.bar2 = 1'b1; t.addr_lo = 32'h0000_0040;
    run_tlp(t);
    chk("bar2_region", rd_addr[13:12], 2'b10);

    compl_done = 1'b1;
    tick();
    compl_done = 1'b0;
    chk("stray_done_tready", tready, 1);
    chk("stray_done_cpl", req_compl, 0);

    t = mk_tlp(7'h00); t.addr_lo = 32'h0000_0010; t.tag = 8'h77; t.rst_in_cpl = 1'b1;
    run_tlp(t);
    t = mk_tlp(7'h20); t.addr_lo = 32'h0000_0FFC; t.addr_hi = 32'h1; t.tag = 8'h78; t.wait_cpl = 3;
    run_tlp(t);

    for (int n = 0; n < 60; n++) begin
      t = mk_tlp(fts[$urandom_range(0, 7)]);
      t.len      = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(2, 3)) : 10'd1;
      t.ep       = ($urandom_range(0, 7) == 0);
      t.bar0     = 1'($urandom());
      t.bar2     = 1'($urandom());
      t.addr_lo  = $urandom();
      t.addr_hi  = $urandom();
      t.fbe      = 4'($urandom());
      t.lbe      = 4'($urandom());
      t.data     = $urandom();
      t.tag      = 8'($urandom());
      t.rid      = 16'($urandom());
      t.tc       = 3'($urandom());
      t.td       = 1'($urandom());
      t.attr     = 2'($urandom());
      t.busy     = $urandom_range(0, 3);
      t.wait_cpl = $urandom_range(1, 6);
      run_tlp(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
